// File: rtl/biriscv_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, keeps one 64-bit icache read in flight and buffers one bundle for decode.
// Optional branch prediction is enabled with the BIRISCV_FETCH_BPRED_EN macro (sequential fetch otherwise).
module biriscv_fetch_ctrl #(
    parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [1:0]  branch_priv_i,

    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,

    input  logic [31:0] next_pc_f_i,
    input  logic [1:0]  next_taken_f_i,

    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_branch_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,
    input  logic        fetch_accept_i
);

    localparam logic [31:0] INST_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DROP,
        ST_FAULT
    } state_t;

    state_t      state_q;
    logic [31:2] pc_q;
    logic [1:0]  priv_q;
    logic [1:0]  pred_q;
    logic [31:2] req_pc_q;

    logic        out_valid_q;
    logic [63:0] out_instr_q;
    logic [31:2] out_pc_q;
    logic [1:0]  out_pred_q;
    logic        out_fault_fetch_q;
    logic        out_fault_page_q;

    logic        issue;
    logic        resp_fault;
    logic [31:2] pc_seq;
    logic [31:2] pc_d;
    logic [1:0]  pred_d;
    logic [63:0] resp_instr;
    logic        unused_bits;

    assign icache_rd_o   = (state_q == ST_RUN) & (!out_valid_q | fetch_accept_i)
                         & !branch_request_i & !rst_i;
    assign icache_pc_o   = {pc_q[31:3], 3'b000};
    assign icache_priv_o = priv_q;
    assign issue         = icache_rd_o & icache_accept_i;
    assign resp_fault    = icache_error_i | icache_page_fault_i;

    // Sequential next fetch block; the 29-bit increment wraps 0xFFFFFFF8 to 0.
    assign pc_seq = {pc_q[31:3] + 29'd1, 1'b0};

`ifdef BIRISCV_FETCH_BPRED_EN
    assign pc_d        = (next_taken_f_i != 2'b00) ? next_pc_f_i[31:2] : pc_seq;
    assign pred_d      = next_taken_f_i;
    assign unused_bits = ^{branch_pc_i[1:0], next_pc_f_i[1:0]};
`else
    assign pc_d        = pc_seq;
    assign pred_d      = 2'b00;
    assign unused_bits = ^{branch_pc_i[1:0], next_pc_f_i, next_taken_f_i};
`endif

    // A target landing on slot1 must not execute slot0; faults deliver an all-zero bundle.
    always_comb begin
        resp_instr = icache_inst_i;
        if (req_pc_q[2])
            resp_instr[31:0] = INST_NOP;
        if (resp_fault)
            resp_instr = 64'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_RUN;
            pc_q              <= BOOT_VECTOR[31:2];
            priv_q            <= 2'b11;
            pred_q            <= 2'b00;
            req_pc_q          <= BOOT_VECTOR[31:2];
            out_valid_q       <= 1'b0;
            out_instr_q       <= 64'd0;
            out_pc_q          <= '0;
            out_pred_q        <= 2'b00;
            out_fault_fetch_q <= 1'b0;
            out_fault_page_q  <= 1'b0;
        end else begin
            if (fetch_accept_i)
                out_valid_q <= 1'b0;

            if (branch_request_i) begin
                pc_q        <= branch_pc_i[31:2];
                priv_q      <= branch_priv_i;
                out_valid_q <= 1'b0;
                // A request still in flight must have its response swallowed.
                if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !icache_valid_i)
                    state_q <= ST_DROP;
                else
                    state_q <= ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (issue) begin
                            pc_q     <= pc_d;
                            pred_q   <= pred_d;
                            req_pc_q <= pc_q;
                            state_q  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (icache_valid_i) begin
                            out_valid_q       <= 1'b1;
                            out_instr_q       <= resp_instr;
                            out_pc_q          <= req_pc_q;
                            out_pred_q        <= pred_q;
                            out_fault_fetch_q <= icache_error_i;
                            out_fault_page_q  <= icache_page_fault_i;
                            state_q           <= resp_fault ? ST_FAULT : ST_RUN;
                        end
                    end
                    ST_DROP: begin
                        if (icache_valid_i)
                            state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_FAULT;
                    end
                endcase
            end
        end
    end

    assign fetch_valid_o       = out_valid_q;
    assign fetch_instr_o       = out_instr_q;
    assign fetch_pc_o          = {out_pc_q, 2'b00};
    assign fetch_pred_branch_o = out_pred_q;
    assign fetch_fault_fetch_o = out_fault_fetch_q;
    assign fetch_fault_page_o  = out_fault_page_q;

endmodule

// File: doc/biriscv_fetch_ctrl.md
# biriscv_fetch_ctrl

Front-end fetch controller that produces the 64-bit fetch bundles consumed by the decode stage. It owns the fetch PC, issues one outstanding 64-bit instruction-cache read at a time, and registers each response into a one-entry output buffer. It presents bundles on a valid/accept handshake and handles branch redirects, including discarding in-flight responses. It sits between the instruction cache and `biriscv_decode`, driving that block's `fetch_in_*` inputs.

## Interface
- `BOOT_VECTOR`, 32'h80000000, PC loaded at reset.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `branch_request_i`  in  1  redirect strobe from exec/CSR; same signal drives decode flush.
- `branch_pc_i`  in  32  redirect target.
- `branch_priv_i`  in  2  privilege for subsequent fetches.
- `icache_rd_o`  out  1  read request.
- `icache_pc_o`  out  32  request address, always `{pc_q[31:3],3'b000}`.
- `icache_priv_o`  out  2  current fetch privilege.
- `icache_accept_i`  in  1  request accepted this cycle.
- `icache_valid_i`  in  1  response valid, one cycle, at least 1 cycle after accept.
- `icache_inst_i`  in  64  response bundle; slot0 = [31:0].
- `icache_error_i`  in  1  bus/access fault.
- `icache_page_fault_i`  in  1  page fault.
- `next_pc_f_i`  in  32  predictor target for `icache_pc_o`.
- `next_taken_f_i`  in  2  predictor taken per slot.
- `fetch_valid_o`  out  1  bundle valid.
- `fetch_instr_o`  out  64  bundle.
- `fetch_pc_o`  out  32  fetch PC of bundle (unaligned, [1:0]=0).
- `fetch_pred_branch_o`  out  2  prediction captured at issue.
- `fetch_fault_fetch_o`  out  1  access fault.
- `fetch_fault_page_o`  out  1  page fault.
- `fetch_accept_i`  in  1  decode accepts bundle.

## Operation
- **State machine:**
  - **RUN**: may issue a request.
  - **WAIT**: a request is outstanding.
  - **DROP**: a request is outstanding but was killed by a redirect.
  - **FAULT**: fetching is halted after a faulting response.
- **Issue:** `icache_rd_o = (state==RUN) & (!out_valid_q | fetch_accept_i) & !branch_request_i & !rst_i`.
- **RUN→WAIT** on `icache_rd_o & icache_accept_i`. On that cycle, latch the prediction and advance `pc_q`:
  - Prediction latched into `pred_q` = `next_taken_f_i`.
  - Next `pc_q` = `next_pc_f_i` if `next_taken_f_i != 0`, else `{pc_q[31:3]+1, 3'b000}`.
  - The sequential increment wraps 0xFFFFFFF8 → 0x00000000.
- **WAIT→RUN** on `icache_valid_i`. The response is loaded into the output register: `out_valid_q=1`, instr, PC of the request, `pred_q`, fault bits.
  - If `icache_error_i | icache_page_fault_i`: instr forced to 0, and WAIT→FAULT instead of RUN.
  - If request PC[2]=1 (misaligned branch target): slot0 replaced by 32'h00000013 (NOP).
- **DROP→RUN** on `icache_valid_i`; the response is discarded.
- **FAULT** stays until `branch_request_i`.
- **Redirect** (`branch_request_i`, any state, highest priority after reset):
  - `pc_q` ← `branch_pc_i`, priv ← `branch_priv_i`, `out_valid_q` ← 0.
  - Next state: DROP if state is WAIT or DROP and `icache_valid_i` is low this cycle; otherwise RUN.
- **Output:** `fetch_valid_o = out_valid_q`. `out_valid_q` clears on `fetch_accept_i` unless reloaded the same cycle.
- **Output buffer cannot overflow:** a request is issued only when the buffer is free, or being freed that cycle.

## Timing
- **Reset:** state=RUN, `pc_q`=`BOOT_VECTOR`, priv=2'b11 (machine), all `fetch_*` outputs 0, `pred_q`=0. `icache_rd_o`=0 while `rst_i` is high; it is 1 the first cycle after reset.
- **Latency:** request accepted at cycle N, response at N+k (k≥1), `fetch_valid_o` at N+k+1.
- **Back-to-back throughput:** one bundle per 2 cycles with a 1-cycle cache.
- **Outputs are registered;** `icache_pc_o`, `icache_priv_o` are direct from registers.
- **Output hold:** outputs hold stable while `fetch_valid_o & !fetch_accept_i`.
- **Response in the same cycle as a redirect:** the response is dropped and the state goes to RUN; the first request to the new target issues the following cycle.
- **Redirect in the same cycle as request accept:** the redirect wins and the request is not issued, because `icache_rd_o` is gated low.

## Configuration
- **`BIRISCV_FETCH_BPRED_EN` defined:** prediction inputs are used as described.
- **`BIRISCV_FETCH_BPRED_EN` undefined:**
  - `next_pc_f_i` and `next_taken_f_i` are ignored.
  - Next PC is always the sequential increment.
  - `fetch_pred_branch_o` is constant 2'b00.

## Test plan
- **Reset then fetch:** release reset, 1-cycle cache, `fetch_accept_i`=1 → requests to 0x80000000, 0x80000008, 0x80000010; bundles delivered in order with matching `fetch_pc_o`.
- **Backpressure:** hold `fetch_accept_i`=0 for 10 cycles after the first bundle → `fetch_valid_o` stays 1 with stable data; no second `icache_rd_o` until accept.
- **Redirect during WAIT:** 3-cycle cache; assert `branch_request_i` with target 0x80001004 the cycle after accept → old response discarded. Next request is 0x80001000, `fetch_pc_o`=0x80001004, slot0=0x00000013.
- **Fault:** response with `icache_page_fault_i`=1 → `fetch_fault_page_o`=1, `fetch_instr_o`=0, no further requests until redirect; after redirect, fetch resumes at target.
- **Prediction (macro on):** `next_taken_f_i`=2'b01, `next_pc_f_i`=0x80000100 → `fetch_pred_branch_o`=01, next request 0x80000100. With the macro off, the same stimulus gives pred=00 and next request 0x80000008.
- **Wrap:** redirect to 0xFFFFFFF8 → following request address is 0x00000000.
